// File: rtl/zigzag_buffer_pkg.sv
// Shared widths, port typedefs and read-FSM state encoding for the zigzag buffer.
package zigzag_buffer_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int BLOCK_SIZE = 64;
  localparam int CODE_WIDTH = 6;

  typedef logic [DATA_WIDTH-1:0] dataPort_t;
  typedef logic [CODE_WIDTH-1:0] codePort_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_READ = 1'b1
  } rd_state_t;

  // Wrapping increment of a 6-bit block counter.
  function automatic codePort_t code_inc(input codePort_t c);
    return c + codePort_t'(1);
  endfunction

endpackage

// File: rtl/zigzag_rom.sv
// Combinational JPEG zigzag table: zigzag position in, raster address out.
module zigzag_rom
  import zigzag_buffer_pkg::*;
(
  input  codePort_t idx,
  output codePort_t addr
);

  localparam codePort_t ZZ [BLOCK_SIZE] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  assign addr = ZZ[idx];

endmodule

// File: rtl/zigzag_buffer.sv
// Ping-pong 8x8 coefficient buffer: raster-order writes, zigzag-order reads.
// Each bank is a simple dual-port RAM whose registered read doubles as the
// output data register, so out_data holds its value between blocks.
module zigzag_buffer #(
  parameter int DATA_WIDTH = zigzag_buffer_pkg::DATA_WIDTH,
  parameter int BLOCK_SIZE = zigzag_buffer_pkg::BLOCK_SIZE
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  output logic                  out_last,
  output logic                  overflow
);
  import zigzag_buffer_pkg::*;

  localparam codePort_t LAST_IDX = codePort_t'(BLOCK_SIZE - 1);

  logic [1:0] full_q, full_d;
  logic       wb_q, wb_d;
  logic       rb_q, rb_d;
  codePort_t  wcnt_q, wcnt_d;
  codePort_t  rcnt_q, rcnt_d;
  rd_state_t  state_q, state_d;
  logic       overflow_q, overflow_d;
  logic       out_valid_q, out_valid_d;
  logic       out_last_q, out_last_d;
  logic       rd_bank_q, rd_bank_d;

  logic       wr_en;
  logic       rd_en;
  logic       rd_done;
  codePort_t  rd_addr;
  logic [DATA_WIDTH-1:0] bank_dout [2];

  // Final read of the current bank; frees it for the writer this same cycle.
  assign rd_done = (state_q == ST_READ) && (rcnt_q == LAST_IDX);

  zigzag_rom u_rom (
    .idx  (rcnt_q),
    .addr (rd_addr)
  );

  // Write side: accept into bank wb unless it is still full (a clear this cycle counts as free).
  always_comb begin
    full_d     = full_q;
    wb_d       = wb_q;
    wcnt_d     = wcnt_q;
    overflow_d = overflow_q;
    wr_en      = 1'b0;
    if (rd_done) begin
      full_d[rb_q] = 1'b0;
    end
    if (in_valid) begin
      if (!full_q[wb_q] || (rd_done && (rb_q == wb_q))) begin
        wr_en  = 1'b1;
        wcnt_d = code_inc(wcnt_q);
        if (wcnt_q == LAST_IDX) begin
          full_d[wb_q] = 1'b1;
          wb_d         = ~wb_q;
          wcnt_d       = '0;
        end
      end else begin
        overflow_d = 1'b1;
      end
    end
  end

  // Read FSM: looks at next-cycle full flags so a block starts reading the cycle after its last write.
  always_comb begin
    state_d     = state_q;
    rcnt_d      = rcnt_q;
    rb_d        = rb_q;
    rd_en       = 1'b0;
    rd_bank_d   = rd_bank_q;
    case (state_q)
      ST_IDLE: begin
        if (full_d[rb_q]) begin
          state_d = ST_READ;
          rcnt_d  = '0;
        end
      end
      ST_READ: begin
        rd_en     = 1'b1;
        rd_bank_d = rb_q;
        rcnt_d    = code_inc(rcnt_q);
        if (rd_done) begin
          rcnt_d = '0;
          rb_d   = ~rb_q;
          if (!full_d[~rb_q]) begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    out_valid_d = rd_en;
    out_last_d  = rd_done;
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      full_q      <= '0;
      wb_q        <= 1'b0;
      rb_q        <= 1'b0;
      wcnt_q      <= '0;
      rcnt_q      <= '0;
      state_q     <= ST_IDLE;
      overflow_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      rd_bank_q   <= 1'b0;
    end else begin
      full_q      <= full_d;
      wb_q        <= wb_d;
      rb_q        <= rb_d;
      wcnt_q      <= wcnt_d;
      rcnt_q      <= rcnt_d;
      state_q     <= state_d;
      overflow_q  <= overflow_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      rd_bank_q   <= rd_bank_d;
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_bank
    logic [DATA_WIDTH-1:0] mem [BLOCK_SIZE];
    logic [DATA_WIDTH-1:0] dout_q;

    // Write port: contents are deliberately left unreset.
    always_ff @(posedge clk) begin
      if (wr_en && (wb_q == 1'(gi))) begin
        mem[wcnt_q] <= in_data;
      end
    end

    // Registered read port; the output register alone is cleared by reset.
    always_ff @(posedge clk) begin
      if (rst) begin
        dout_q <= '0;
      end else if (rd_en && (rb_q == 1'(gi))) begin
        dout_q <= mem[rd_addr];
      end
    end

    assign bank_dout[gi] = dout_q;
  end

  assign out_data  = bank_dout[rd_bank_q];
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_zigzag_buffer.sv
// Directed self-checking bench for zigzag_buffer.
module tb_zigzag_buffer;
  import zigzag_buffer_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  dataPort_t   in_data = '0;
  logic        in_valid = 1'b0;
  dataPort_t   out_data;
  logic        out_valid;
  logic        out_last;
  logic        overflow;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int last_in_cyc = 0;

  int zz [64] = '{
     0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
    12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
    35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
    58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
  };

  typedef struct {
    logic [15:0] d;
    logic        l;
    int          c;
  } cap_t;
  cap_t cap_q [$];

  zigzag_buffer #(.DATA_WIDTH(16), .BLOCK_SIZE(64)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_last  (out_last),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (out_valid === 1'b1) cap_q.push_back('{out_data, out_last, cyc});
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; in_valid = 1'b0; in_data = '0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    cap_q.delete();
  endtask

  task automatic send(input logic [15:0] d);
    in_valid = 1'b1;
    in_data = d;
    last_in_cyc = cyc;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_cmp++; if (out_last !== 1'b0) begin n_err++; $display("FAIL reset_out_last got %b want 0", out_last); end
    n_cmp++; if (out_data !== 16'd0) begin n_err++; $display("FAIL reset_out_data got %0d want 0", out_data); end
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow got %b want 0", overflow); end
    rst = 1'b0;
    $display("test_reset done");
  endtask

  task automatic test_single_block();
    logic [15:0] e;
    do_reset();
    for (int i = 0; i < 64; i++) send(16'(i));
    for (int t = 0; t < 200 && cap_q.size() < 64; t++) @(posedge clk);
    idle(10);
    n_cmp++; if (cap_q.size() != 64) begin n_err++; $display("FAIL single_count got %0d want 64", cap_q.size()); end
    n_cmp++;
    if (cap_q.size() == 0 || cap_q[0].c != last_in_cyc + 2) begin
      n_err++; $display("FAIL single_latency got %0d want %0d", (cap_q.size() == 0) ? -1 : cap_q[0].c, last_in_cyc + 2);
    end
    for (int k = 0; k < 64 && k < cap_q.size(); k++) begin
      e = 16'(zz[k]);
      n_cmp++; if (cap_q[k].d !== e) begin n_err++; $display("FAIL single_data[%0d] got %0d want %0d", k, cap_q[k].d, e); end
      n_cmp++; if (cap_q[k].l !== (k == 63)) begin n_err++; $display("FAIL single_last[%0d] got %b want %b", k, cap_q[k].l, k == 63); end
      n_cmp++; if (cap_q[k].c != cap_q[0].c + k) begin n_err++; $display("FAIL single_contig[%0d] got %0d want %0d", k, cap_q[k].c, cap_q[0].c + k); end
    end
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL single_overflow got %b want 0", overflow); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL single_idle_valid got %b want 0", out_valid); end
    n_cmp++; if (out_data !== 16'd63) begin n_err++; $display("FAIL single_hold_data got %0d want 63", out_data); end
    $display("test_single_block done: %0d outputs", cap_q.size());
  endtask

  task automatic test_back_to_back();
    logic [15:0] e;
    do_reset();
    for (int j = 0; j < 256; j++) send(16'(j));
    for (int t = 0; t < 400 && cap_q.size() < 256; t++) @(posedge clk);
    idle(10);
    n_cmp++; if (cap_q.size() != 256) begin n_err++; $display("FAIL b2b_count got %0d want 256", cap_q.size()); end
    for (int k = 0; k < 256 && k < cap_q.size(); k++) begin
      e = 16'((k / 64) * 64 + zz[k % 64]);
      n_cmp++; if (cap_q[k].d !== e) begin n_err++; $display("FAIL b2b_data[%0d] got %0d want %0d", k, cap_q[k].d, e); end
      n_cmp++; if (cap_q[k].l !== (k % 64 == 63)) begin n_err++; $display("FAIL b2b_last[%0d] got %b want %b", k, cap_q[k].l, k % 64 == 63); end
      n_cmp++; if (cap_q[k].c != cap_q[0].c + k) begin n_err++; $display("FAIL b2b_contig[%0d] got %0d want %0d", k, cap_q[k].c, cap_q[0].c + k); end
    end
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL b2b_overflow got %b want 0", overflow); end
    $display("test_back_to_back done: %0d outputs", cap_q.size());
  endtask

  task automatic test_gaps();
    logic [15:0] e;
    do_reset();
    for (int j = 0; j < 128; j++) begin
      send(16'(1000 + j));
      if ($urandom_range(0, 1) == 1) idle(1);
    end
    for (int t = 0; t < 400 && cap_q.size() < 128; t++) @(posedge clk);
    idle(10);
    n_cmp++; if (cap_q.size() != 128) begin n_err++; $display("FAIL gaps_count got %0d want 128", cap_q.size()); end
    for (int k = 0; k < 128 && k < cap_q.size(); k++) begin
      e = 16'(1000 + (k / 64) * 64 + zz[k % 64]);
      n_cmp++; if (cap_q[k].d !== e) begin n_err++; $display("FAIL gaps_data[%0d] got %0d want %0d", k, cap_q[k].d, e); end
      n_cmp++; if (cap_q[k].l !== (k % 64 == 63)) begin n_err++; $display("FAIL gaps_last[%0d] got %b want %b", k, cap_q[k].l, k % 64 == 63); end
    end
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL gaps_overflow got %b want 0", overflow); end
    $display("test_gaps done: %0d outputs", cap_q.size());
  endtask

  task automatic test_overflow();
    logic [15:0] e;
    do_reset();
    force dut.state_q = ST_IDLE;
    for (int j = 0; j < 192; j++) begin
      send(16'(500 + j));
      if (j == 127) begin
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_before got %b want 0", overflow); end
      end
      if (j == 128) begin
        n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_at_129 got %b want 1", overflow); end
      end
    end
    idle(20);
    n_cmp++; if (cap_q.size() != 0) begin n_err++; $display("FAIL ovf_stalled_out got %0d want 0", cap_q.size()); end
    n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_held got %b want 1", overflow); end
    release dut.state_q;
    for (int t = 0; t < 400 && cap_q.size() < 128; t++) @(posedge clk);
    idle(20);
    n_cmp++; if (cap_q.size() != 128) begin n_err++; $display("FAIL ovf_drain_count got %0d want 128", cap_q.size()); end
    for (int k = 0; k < 128 && k < cap_q.size(); k++) begin
      e = 16'(500 + (k / 64) * 64 + zz[k % 64]);
      n_cmp++; if (cap_q[k].d !== e) begin n_err++; $display("FAIL ovf_data[%0d] got %0d want %0d", k, cap_q[k].d, e); end
      n_cmp++; if (cap_q[k].l !== (k % 64 == 63)) begin n_err++; $display("FAIL ovf_last[%0d] got %b want %b", k, cap_q[k].l, k % 64 == 63); end
    end
    n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_held_after got %b want 1", overflow); end
    $display("test_overflow done: %0d outputs", cap_q.size());
  endtask

  task automatic test_reset_mid_input();
    logic [15:0] e;
    do_reset();
    for (int j = 0; j < 30; j++) send(16'(7000 + j));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    idle(5);
    n_cmp++; if (cap_q.size() != 0) begin n_err++; $display("FAIL rstin_partial_out got %0d want 0", cap_q.size()); end
    for (int j = 0; j < 64; j++) send(16'(100 + j));
    for (int t = 0; t < 200 && cap_q.size() < 64; t++) @(posedge clk);
    idle(10);
    n_cmp++; if (cap_q.size() != 64) begin n_err++; $display("FAIL rstin_count got %0d want 64", cap_q.size()); end
    for (int k = 0; k < 64 && k < cap_q.size(); k++) begin
      e = 16'(100 + zz[k]);
      n_cmp++; if (cap_q[k].d !== e) begin n_err++; $display("FAIL rstin_data[%0d] got %0d want %0d", k, cap_q[k].d, e); end
    end
    $display("test_reset_mid_input done: %0d outputs", cap_q.size());
  endtask

  task automatic test_reset_mid_read();
    logic [15:0] e;
    bit found;
    bit saw_valid;
    do_reset();
    for (int j = 0; j < 64; j++) send(16'(300 + j));
    found = 1'b0;
    for (int t = 0; t < 300 && !found; t++) begin
      if (dut.state_q == ST_READ && dut.rcnt_q == 6'd20) found = 1'b1;
      else begin @(posedge clk); #1; end
    end
    n_cmp++; if (found !== 1'b1) begin n_err++; $display("FAIL rstrd_reach_rcnt20 got %b want 1", found); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rstrd_valid_next got %b want 0", out_valid); end
    n_cmp++; if (cap_q.size() != 20) begin n_err++; $display("FAIL rstrd_partial_count got %0d want 20", cap_q.size()); end
    saw_valid = 1'b0;
    for (int t = 0; t < 100; t++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) saw_valid = 1'b1;
    end
    n_cmp++; if (saw_valid !== 1'b0) begin n_err++; $display("FAIL rstrd_quiet got %b want 0", saw_valid); end
    n_cmp++; if (out_data !== 16'd0) begin n_err++; $display("FAIL rstrd_out_data got %0d want 0", out_data); end
    cap_q.delete();
    for (int j = 0; j < 64; j++) send(16'(400 + j));
    for (int t = 0; t < 200 && cap_q.size() < 64; t++) @(posedge clk);
    idle(10);
    n_cmp++; if (cap_q.size() != 64) begin n_err++; $display("FAIL rstrd_new_count got %0d want 64", cap_q.size()); end
    for (int k = 0; k < 64 && k < cap_q.size(); k++) begin
      e = 16'(400 + zz[k]);
      n_cmp++; if (cap_q[k].d !== e) begin n_err++; $display("FAIL rstrd_data[%0d] got %0d want %0d", k, cap_q[k].d, e); end
    end
    $display("test_reset_mid_read done: %0d outputs", cap_q.size());
  endtask

  initial begin
    test_reset();
    test_single_block();
    test_back_to_back();
    test_gaps();
    test_overflow();
    test_reset_mid_input();
    test_reset_mid_read();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/zigzag_buffer.md
ZIGZAG_BUFFER -- requirements
Module: zigzag_buffer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, coefficient width.
REQ-002 SHALL have parameter BLOCK_SIZE, default 64, coefficients per 8x8 block; only 64 is supported.
REQ-003 SHALL have port clk, input, 1, single clock; all logic rising-edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port in_data, input, DATA_WIDTH, quantised coefficient, raster order (row-major).
REQ-006 SHALL have port in_valid, input, 1, in_data valid this cycle; no backpressure.
REQ-007 SHALL have port out_data, output, DATA_WIDTH, coefficient in zigzag order.
REQ-008 SHALL have port out_valid, output, 1, out_data valid this cycle.
REQ-009 SHALL have port out_last, output, 1, high with out_valid on the 64th coefficient of a block.
REQ-010 SHALL have port overflow, output, 1, sticky flag set when an input sample is dropped.

Function
REQ-011 SHALL store input in two ping-pong banks of BLOCK_SIZE x DATA_WIDTH; write address = raster index 0..63.
REQ-012 SHALL keep per-bank flag full[b], write bank pointer wb, read bank pointer rb, 6-bit write counter wcnt, 6-bit read counter rcnt.
REQ-013 SHALL, on in_valid with full[wb]=0, write in_data to bank wb at wcnt and increment wcnt.
REQ-014 SHALL, on the write with wcnt=63, set full[wb], toggle wb, wrap wcnt to 0.
REQ-015 SHALL, on in_valid with full[wb]=1 and no clear of bank wb that cycle, drop the sample, leave wcnt unchanged, set overflow.
REQ-016 SHALL treat a full[wb] clear in the same cycle as a write as permitting the write (clear wins).
REQ-017 SHALL run a read FSM with states IDLE and READ.
REQ-018 SHALL transition IDLE->READ when full[rb]=1, with rcnt=0.
REQ-019 SHALL, in READ, issue bank rb address zz[rcnt] each cycle and increment rcnt.
REQ-020 SHALL, at rcnt=63, clear full[rb], toggle rb, wrap rcnt, then stay in READ if the other bank is full, else go to IDLE (no gap back-to-back).
REQ-021 SHALL implement zz as the JPEG zigzag table: zz[0..9]=0,1,8,16,9,2,3,10,17,24; zz[63]=63.
REQ-022 SHALL use a synchronous read: out_data/out_valid appear 1 cycle after address issue.
REQ-023 SHALL present the first coefficient of a block 2 cycles after the cycle in which its 64th input was sampled, when the read side is idle.
REQ-024 SHALL assert out_last together with the data read at rcnt=63.
REQ-025 SHALL sustain 1 coefficient/cycle in and out indefinitely without overflow.
REQ-026 SHALL keep out_data at its last value when out_valid=0.

Reset
REQ-027 SHALL, on rst, clear full[1:0], wb, rb, wcnt, rcnt, FSM->IDLE, out_data=0, out_valid=0, out_last=0, overflow=0.
REQ-028 SHALL, on rst mid-block (either side), discard the partial block; no output until 64 new inputs arrive.
REQ-029 SHALL NOT reset bank memory contents.

Structure
REQ-030 SHALL take DATA_WIDTH, BLOCK_SIZE and the dataPort_t/codePort_t typedefs from the shared package.
REQ-031 SHALL place the 64x6 zigzag table in a sub-module zigzag_rom (combinational, index in, raster address out).
REQ-032 SHALL infer the banks as simple dual-port RAM (one write port, one read port).

Verification
REQ-033 SHALL pass: 64 continuous inputs, value = raster index -> outputs 0,1,8,16,9,2,3,10,...,63; first out_valid 2 cycles after the last input; out_last on 63.
REQ-034 SHALL pass: 4 back-to-back blocks at 1/cycle -> 256 contiguous out_valid cycles, out_last every 64th, overflow=0.
REQ-035 SHALL pass: inputs with random gaps (50% in_valid) -> identical zigzag output per block, no overflow.
REQ-036 SHALL pass: 192 inputs at 1/cycle with read stalled by forcing the FSM -> 129th input dropped, overflow=1 and held.
REQ-037 SHALL pass: rst after 30 inputs, then 64 inputs valued 100+i -> first block out starts 100,101,108; no stale data.
REQ-038 SHALL pass: rst asserted during READ at rcnt=20 -> out_valid=0 next cycle, stays 0 until a new full block arrives.
